// File: rtl/eb_pkg.sv
// Shared types and helpers for the eb_pack width upsizer.
package eb_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   function automatic int cnt_width(input int ratio);
      return $clog2(ratio + 32'sd1);
   endfunction

   // A single-lane build still needs a one-bit index to keep the ports legal.
   function automatic int idx_width(input int ratio);
      return (ratio > 32'sd1) ? $clog2(ratio) : 32'sd1;
   endfunction

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/eb_pack_ctrl.sv
// Handshake, FILL/FULL state and lane index for eb_pack; emits lane write
// enables plus clear-word and complete strobes for the datapath.
module eb_pack_ctrl
   import eb_pkg::*;
#(
   parameter  int RATIO = 4,
   localparam int IDX_W = idx_width(RATIO)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t_0_valid,
   input  logic             t_0_last,
   input  logic             i_0_ready,
   output logic             t_0_ready,
   output logic             i_0_valid,
   output logic [RATIO-1:0] lane_we,
   output logic [IDX_W-1:0] wr_lane,
   output logic             clear_word,
   output logic             complete
);

   state_e           state_r, state_nxt_s;
   logic [IDX_W-1:0] idx_r, idx_nxt_s;
   logic             t_0_ready_s, accept_s, retire_s, complete_s, clear_word_s;
   logic [IDX_W-1:0] wr_lane_s;
   logic [RATIO-1:0] lane_we_s;

   // Handshake decode, lane strobes and next-state selection.
   always_comb begin
      t_0_ready_s = 1'b0;
      wr_lane_s   = '0;
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;

      case (state_r)
         FILL: begin
            t_0_ready_s = 1'b1;
            wr_lane_s   = idx_r;
         end
         FULL: begin
            t_0_ready_s = i_0_ready;
            wr_lane_s   = '0;
         end
         default: begin
            t_0_ready_s = 1'b0;
            wr_lane_s   = '0;
         end
      endcase

      accept_s     = t_0_valid && t_0_ready_s;
      retire_s     = (state_r == FULL) && i_0_ready;
      complete_s   = accept_s && (t_0_last || (wr_lane_s == IDX_W'(RATIO - 1)));
      // A beat landing in lane 0 starts a fresh word, so stale upper lanes go.
      clear_word_s = (accept_s && (wr_lane_s == IDX_W'(0))) || retire_s;

      for (int k = 0; k < RATIO; k++) begin
         lane_we_s[k] = accept_s && (wr_lane_s == IDX_W'(k));
      end

      case (state_r)
         FILL: begin
            if (complete_s) begin
               state_nxt_s = FULL;
               idx_nxt_s   = '0;
            end else if (accept_s) begin
               state_nxt_s = FILL;
               idx_nxt_s   = idx_r + IDX_W'(1);
            end else begin
               state_nxt_s = FILL;
               idx_nxt_s   = idx_r;
            end
         end
         FULL: begin
            if (retire_s) begin
               if (complete_s) begin
                  state_nxt_s = FULL;
                  idx_nxt_s   = '0;
               end else if (accept_s) begin
                  state_nxt_s = FILL;
                  idx_nxt_s   = IDX_W'(1);
               end else begin
                  state_nxt_s = FILL;
                  idx_nxt_s   = '0;
               end
            end else begin
               state_nxt_s = FULL;
               idx_nxt_s   = idx_r;
            end
         end
         default: begin
            state_nxt_s = FILL;
            idx_nxt_s   = '0;
         end
      endcase
   end

   // State and lane index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= FILL;
         idx_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
      end
   end

   assign t_0_ready  = t_0_ready_s;
   assign i_0_valid  = (state_r == FULL);
   assign lane_we    = lane_we_s;
   assign wr_lane    = wr_lane_s;
   assign clear_word = clear_word_s;
   assign complete   = complete_s;

endmodule

// File: rtl/eb_pack.sv
// Elastic-stream width upsizer: packs RATIO narrow beats into one wide word,
// with early close on t_0_last and a filled-lane count per word.
module eb_pack
   import eb_pkg::*;
#(
   parameter  int T_0_WIDTH = 8,
   parameter  int RATIO     = 4,
   localparam int I_0_WIDTH = T_0_WIDTH * RATIO,
   localparam int CNT_WIDTH = cnt_width(RATIO),
   localparam int IDX_W     = idx_width(RATIO)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [T_0_WIDTH-1:0] t_0_data,
   input  logic                 t_0_valid,
   input  logic                 t_0_last,
   output logic                 t_0_ready,
   output logic [I_0_WIDTH-1:0] i_0_data,
   output logic                 i_0_valid,
   output logic                 i_0_last,
   output logic [CNT_WIDTH-1:0] i_0_count,
   input  logic                 i_0_ready
);

   logic [I_0_WIDTH-1:0] data_r;
   logic [CNT_WIDTH-1:0] count_r;
   logic                 last_r;
   logic [RATIO-1:0]     lane_we_s;
   logic [IDX_W-1:0]     wr_lane_s;
   logic                 clear_word_s, complete_s, valid_s, retire_s;

   eb_pack_ctrl #(
      .RATIO (RATIO)
   ) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .t_0_valid  (t_0_valid),
      .t_0_last   (t_0_last),
      .i_0_ready  (i_0_ready),
      .t_0_ready  (t_0_ready),
      .i_0_valid  (valid_s),
      .lane_we    (lane_we_s),
      .wr_lane    (wr_lane_s),
      .clear_word (clear_word_s),
      .complete   (complete_s)
   );

   assign retire_s = valid_s && i_0_ready;

   // Lane data, lane count and last-flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r  <= '0;
         count_r <= '0;
         last_r  <= 1'b0;
      end else begin
         for (int k = 0; k < RATIO; k++) begin
            if (lane_we_s[k]) begin
               data_r[lane_lo(k, T_0_WIDTH) +: T_0_WIDTH] <= t_0_data;
            end else if (clear_word_s) begin
               data_r[lane_lo(k, T_0_WIDTH) +: T_0_WIDTH] <= '0;
            end else begin
               data_r[lane_lo(k, T_0_WIDTH) +: T_0_WIDTH] <= data_r[lane_lo(k, T_0_WIDTH) +: T_0_WIDTH];
            end
         end
         if (complete_s) begin
            count_r <= CNT_WIDTH'(wr_lane_s) + CNT_WIDTH'(1);
            last_r  <= t_0_last;
         end else if (retire_s) begin
            count_r <= '0;
            last_r  <= 1'b0;
         end else begin
            count_r <= count_r;
            last_r  <= last_r;
         end
      end
   end

   assign i_0_data  = data_r;
   assign i_0_valid = valid_s;
   assign i_0_last  = last_r;
   assign i_0_count = count_r;

endmodule

// File: doc/eb_pack.md
Name: eb_pack

Overview:
- Elastic-stream width upsizer placed directly downstream of an elastic buffer stage.
- Accepts narrow beats on a valid/ready target port and packs RATIO consecutive beats into one wide word on a valid/ready initiator port.
- A beat flagged last closes a partial word early; the word reports its filled-lane count.
- Full throughput: one narrow beat per cycle in, one wide word per RATIO cycles out, with no bubbles.

Parameters:
- T_0_WIDTH, 8, narrow beat width in bits (>=1).
- RATIO, 4, narrow beats per wide word (>=1).
- I_0_WIDTH, T_0_WIDTH*RATIO, wide word width; derived, never overridden.
- CNT_WIDTH, $clog2(RATIO+1), width of the lane-count field; derived.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- t_0_data  in  T_0_WIDTH  narrow beat.
- t_0_valid  in  1  beat valid.
- t_0_last  in  1  final beat of packet; qualified by t_0_valid.
- t_0_ready  out  1  beat accepted when t_0_valid && t_0_ready.
- i_0_data  out  I_0_WIDTH  packed word; lane k at bits [k*T_0_WIDTH +: T_0_WIDTH], lane 0 = first beat.
- i_0_valid  out  1  word valid.
- i_0_last  out  1  word closed by t_0_last.
- i_0_count  out  CNT_WIDTH  filled lanes, 1..RATIO, valid while i_0_valid.
- i_0_ready  in  1  word accepted when i_0_valid && i_0_ready.

Behaviour:
- Reset (sync, active-high, at posedge): i_0_valid=0, i_0_last=0, i_0_count=0, i_0_data=0, lane index=0.
  - Any partial word or unconsumed word is discarded.
  - t_0_ready=1 in the first cycle after reset.
- Handshakes:
  - Both sides are standard valid/ready. Data transfers only when valid && ready are both high at a clock edge.
  - While i_0_valid=1 and i_0_ready=0, i_0_data, i_0_last and i_0_count hold stable.
  - i_0_valid never depends combinationally on i_0_ready. t_0_ready may depend combinationally on i_0_ready.
- Control states:
  - FILL (i_0_valid=0): t_0_ready=1.
    - Each accepted beat is written to lane index `idx`, and idx increments.
    - When the beat fills lane RATIO-1, or has t_0_last=1: set i_0_valid=1, i_0_count=idx+1, i_0_last=t_0_last, idx=0, then go to FULL.
  - FULL (i_0_valid=1): t_0_ready = i_0_ready.
    - If i_0_ready=1 and no beat arrives: i_0_valid=0, go to FILL.
    - If i_0_ready=1 and a beat is accepted in the same cycle: the old word retires and the beat enters lane 0 of a fresh word.
      - If that beat also completes a word (RATIO=1, or t_0_last=1), i_0_valid stays 1 with the new contents.
      - Otherwise go to FILL with idx=1.
- Lane clearing:
  - When a fresh word starts, lanes not yet written read as zero.
  - A partial word presents zeros in lanes >= i_0_count.
- Latency: a word is visible on i_0_* the cycle after its completing beat is accepted.
- Throughput: sustained 1 beat/cycle when i_0_ready is held high.
- Boundary conditions:
  - t_0_last on lane RATIO-1 gives i_0_count=RATIO and i_0_last=1.
  - t_0_last on lane 0 gives i_0_count=1.
  - idx wraps from RATIO-1 to 0. It never exceeds RATIO-1.
  - RATIO=1 degenerates to a one-deep elastic register with count always 1.
  - Reset asserted mid-word: the partial data is lost and no word is emitted.
  - t_0_last with t_0_valid=0 is ignored.

Decomposition:
- Shared package eb_pkg: clog2-based CNT_WIDTH helper and a lane-select function (lane k slice).
- Sub-module eb_pack_ctrl: handshake logic, FILL/FULL state, and lane index counter. It outputs per-lane write enables, a clear-word strobe and a complete strobe.
- Top eb_pack holds the data/count/last registers and instantiates eb_pack_ctrl, mirroring the existing data/ctrl split.

Test Plan:
- Steady stream: T_0_WIDTH=8, RATIO=4, beats 0x11,0x22,0x33,0x44, i_0_ready=1 → one cycle after the 4th beat: i_0_data=0x44332211, i_0_count=4, i_0_last=0.
- Partial packet: beats 0xAA,0xBB with last on 0xBB → i_0_data=0x0000BBAA, i_0_count=2, i_0_last=1. The next word starts at lane 0.
- Backpressure: word complete and i_0_ready=0 for 5 cycles → t_0_ready=0 and outputs are held. Release with a new beat 0x55 in the same cycle → old word accepted and 0x55 lands in lane 0. No beat lost or duplicated over 64 random beats, checked against a scoreboard.
- Back-to-back single-beat packets: last=1 on every beat, i_0_ready=1 → one word per cycle with count=1, upper lanes zero, sustained throughput.
- Mid-word reset: 3 beats accepted, then reset high for 1 cycle → no word emitted, all outputs 0. The next 4 beats form a clean word.
- RATIO=1 build: random valid/ready toggling → i_0_data equals the input sequence in order, with count=1 always.
